// File: rtl/hbm_val_rd_arbiter.sv
// Round-robin arbiter sharing one HBM read channel among NUM_REQ requesters.
// Burst owners are queued in order so R beats are routed back to whoever issued the AR.
module hbm_val_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 256,
    parameter int OT_DEPTH   = 8
) (
    input  logic                          axis_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    output logic                          err_orphan_r,
    output logic                          dbg_state,
    output logic [$clog2(OT_DEPTH):0]     dbg_fifo_count
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and payload is held stable while valid is high and ready low.

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CW = $clog2(OT_DEPTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  arvalid_q, arvalid_d;
    logic [GW-1:0]         mem_q [OT_DEPTH];
    logic [GW-1:0]         mem_d [OT_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;

    logic                  grant_found;
    logic [GW-1:0]         grant_idx;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [GW-1:0]         head;
    logic                  ar_push;
    logic                  r_pop;

    assign fifo_full  = (count_q == CW'(OT_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // Search upward from the requester after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        int            idx;
        logic [GW-1:0] sel;
        idx         = 0;
        sel         = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            sel = GW'(idx);
            if (!grant_found && s_arvalid[sel]) begin
                grant_found = 1'b1;
                grant_idx   = sel;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        s_arready    = '0;
        ar_push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && grant_found && !fifo_full) begin
                    s_arready[grant_idx] = 1'b1;
                    araddr_d     = s_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    arlen_d      = s_arlen[grant_idx*8 +: 8];
                    last_grant_d = grant_idx;
                    owner_d      = grant_idx;
                    arvalid_d    = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (m_arready) begin
                    ar_push   = 1'b1;
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_rvalid = '0;
        m_rready = !rst && !fifo_empty && s_rready[head];
        if (!rst && m_rvalid && !fifo_empty) begin
            s_rvalid[head] = 1'b1;
        end
        r_pop = m_rvalid && m_rready && m_rlast;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ar_push) begin
            mem_d[wr_ptr_q] = owner_q;
            wr_ptr_d = (wr_ptr_q == PW'(OT_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (r_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(OT_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({ar_push, r_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q | (m_rvalid && fifo_empty);
    end

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            owner_q      <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            for (int i = 0; i < OT_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    assign m_arvalid      = arvalid_q;
    assign m_araddr       = araddr_q;
    assign m_arlen        = arlen_q;
    assign m_arsize       = 3'($clog2(DATA_WIDTH / 8));
    assign m_arburst      = 2'b01;
    assign s_rdata        = m_rdata;
    assign s_rresp        = m_rresp;
    assign s_rlast        = m_rlast;
    assign err_orphan_r   = err_q;
    assign dbg_state      = state_q;
    assign dbg_fifo_count = count_q;

endmodule

// File: tb/tb_hbm_val_rd_arbiter.sv
// Directed bench for hbm_val_rd_arbiter: grants, owner routing, FIFO stall, backpressure,
// orphan beats and mid-burst reset, all with hand-computed expectations.
module tb_hbm_val_rd_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   s_arvalid, s_arready, s_rvalid, s_rready;
    logic [191:0] s_araddr;
    logic [31:0]  s_arlen;
    logic [255:0] s_rdata, m_rdata;
    logic [1:0]   s_rresp, m_rresp;
    logic         s_rlast, m_rlast;
    logic         m_arvalid, m_arready;
    logic [47:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic         m_rvalid, m_rready;
    logic         err_orphan_r;
    logic         dbg_state;
    logic [1:0]   dbg_fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    hbm_val_rd_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(48), .DATA_WIDTH(256), .OT_DEPTH(2)
    ) dut (
        .axis_clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast),
        .err_orphan_r(err_orphan_r), .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rresp   = 2'b00;
        m_rdata   = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int grants;
        int beats;
        int ar_count;
        logic [3:0] drop_mask;

        for (int i = 0; i < 4; i++) begin
            s_araddr[i*48 +: 48] = 48'(i * 'h100);
            s_arlen[i*8 +: 8]    = 8'h00;
        end

        // reset state
        reset_dut();
        check("rst_arvalid", m_arvalid, 0);
        check("rst_arready", s_arready, 0);
        check("rst_rready", m_rready, 0);
        check("rst_err", err_orphan_r, 0);
        check("rst_count", dbg_fifo_count, 0);
        check("rst_state", dbg_state, 0);

        // 1: single 4-beat burst from req0
        s_araddr[47:0] = 48'h1000;
        s_arlen[7:0]   = 8'd3;
        s_arvalid      = 4'b0001;
        #1;
        check("t1_arready", s_arready, 4'b0001);
        tick();
        s_arvalid = '0;
        #1;
        check("t1_arvalid", m_arvalid, 1);
        check("t1_araddr", m_araddr, 48'h1000);
        check("t1_arlen", m_arlen, 3);
        check("t1_arsize", m_arsize, 5);
        check("t1_arburst", m_arburst, 1);
        check("t1_arready_issue", s_arready, 0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        check("t1_count_1", dbg_fifo_count, 1);
        s_rready = 4'hF;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = 256'(b + 'hA0);
            m_rlast  = (b == 3);
            #1;
            check("t1_rvalid", s_rvalid, 4'b0001);
            check("t1_rready", m_rready, 1);
            check("t1_rdata", s_rdata[63:0], 64'(b + 'hA0));
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        check("t1_count_0", dbg_fifo_count, 0);
        s_araddr[47:0] = 48'h0;
        s_arlen[7:0]   = 8'd0;

        // 2: all requesters high, 8 grants in round-robin order, beats back to owners
        reset_dut();
        s_arvalid = 4'hF;
        s_rready  = 4'hF;
        grants    = 0;
        beats     = 0;
        ar_count  = 0;
        for (int cyc = 0; cyc < 100 && !(grants == 8 && beats == 8); cyc++) begin
            if (grants == 8) s_arvalid = '0;
            m_arready = m_arvalid;
            m_rvalid  = (exp_q.size() != 0);
            m_rlast   = 1'b1;
            m_rdata   = 256'(beats + 'h50);
            #1;
            if (s_arready != 0) begin
                check("t2_grant", s_arready, 4'b1 << (grants % 4));
                grants++;
            end
            if (m_rvalid) begin
                check("t2_rvalid", s_rvalid, 4'b1 << exp_q[0]);
                check("t2_rready", m_rready, 1);
                if (m_rready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            if (m_arvalid && m_arready) begin
                check("t2_araddr", m_araddr, 48'((ar_count % 4) * 'h100));
                exp_q.push_back(2'(ar_count % 4));
                ar_count++;
            end
            tick();
        end
        check("t2_done", (grants == 8 && beats == 8), 1);
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        exp_q.delete();

        // 3: FIFO of depth 2 fills, third request stalls until the first rlast pop
        reset_dut();
        m_arready = 1'b1;
        s_arvalid = 4'b0111;
        grants    = 0;
        drop_mask = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            s_arvalid = s_arvalid & ~drop_mask;
            #1;
            if (s_arready != 0) begin
                check("t3_grant", s_arready, 4'b1 << grants);
                grants++;
            end
            drop_mask = s_arready;
            tick();
        end
        check("t3_ar_count", grants, 2);
        check("t3_fifo_full", dbg_fifo_count, 2);
        check("t3_stall", s_arready, 0);
        s_rready = 4'hF;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        #1;
        check("t3_rvalid0", s_rvalid, 4'b0001);
        check("t3_rready0", m_rready, 1);
        check("t3_stall_pop", s_arready, 0);
        tick();
        m_rvalid = 1'b0;
        #1;
        check("t3_third_grant", s_arready, 4'b0100);
        tick();
        s_arvalid = '0;
        #1;
        check("t3_araddr2", m_araddr, 48'h200);
        tick();
        m_arready = 1'b0;
        check("t3_count_2", dbg_fifo_count, 2);

        // 4: head=1 with s_rready[1] low holds the beat
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = 4'b1101;
        #1;
        check("t4_rready_low", m_rready, 0);
        check("t4_rvalid_held", s_rvalid, 4'b0010);
        tick();
        check("t4_rvalid_held2", s_rvalid, 4'b0010);
        check("t4_count_held", dbg_fifo_count, 2);
        s_rready = 4'hF;
        #1;
        check("t4_rready_high", m_rready, 1);
        tick();
        check("t4_head2", s_rvalid, 4'b0100);
        check("t4_count_1", dbg_fifo_count, 1);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        check("t4_count_0", dbg_fifo_count, 0);

        // 5: orphan beat with nothing outstanding
        m_rvalid = 1'b1;
        #1;
        check("t5_rready", m_rready, 0);
        check("t5_rvalid", s_rvalid, 0);
        check("t5_err_before", err_orphan_r, 0);
        tick();
        m_rvalid = 1'b0;
        check("t5_err_set", err_orphan_r, 1);
        tick();
        check("t5_err_sticky", err_orphan_r, 1);

        // 6: reset while an AR is stuck in ISSUE
        s_arvalid = 4'b0010;
        #1;
        check("t6_grant1", s_arready, 4'b0010);
        tick();
        s_arvalid = '0;
        m_arready = 1'b0;
        check("t6_issue", m_arvalid, 1);
        check("t6_state_issue", dbg_state, 1);
        rst       = 1'b1;
        s_arvalid = 4'b1001;
        #1;
        check("t6_arready_in_rst", s_arready, 0);
        tick();
        check("t6_arvalid", m_arvalid, 0);
        check("t6_count", dbg_fifo_count, 0);
        check("t6_err", err_orphan_r, 0);
        check("t6_state", dbg_state, 0);
        rst = 1'b0;
        #1;
        check("t6_priority", s_arready, 4'b0001);
        tick();
        s_arvalid = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
